seq_shift_add_multiplier: RTL and testbench



---
 rtl/mult_pkg.sv | 23 ++
 rtl/mult_shift_add_dp.sv | 82 ++++++++
 rtl/seq_shift_add_multiplier.sv | 99 +++++++++
 tb/tb_seq_shift_add_multiplier.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier.
// Optional signed mode is selected by the MULT_SIGNED_EN macro in the users of this package.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int PROD_FACTOR = 2;

    function automatic int cnt_width(input int w);
        int c;
        c = $clog2(w);
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int prod_width(input int w);
        return PROD_FACTOR * w;
    endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Datapath: multiplicand register, accumulator, WIDTH+1-bit adder and right shifter.
// With MULT_SIGNED_EN, operand magnitudes are taken at load and the final product negated on request.
module mult_shift_add_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         step,
`ifdef MULT_SIGNED_EN
    input  logic                         negate,
    input  logic                         sgn,
`endif
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    output logic [prod_width(WIDTH)-1:0] result
);

    localparam int PW = prod_width(WIDTH);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    shifted;

`ifdef MULT_SIGNED_EN
    logic neg_q, neg_d;

    // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        a_mag = (sgn && a[WIDTH-1]) ? WIDTH'(~a + 1'b1) : a;
        b_mag = (sgn && b[WIDTH-1]) ? WIDTH'(~b + 1'b1) : b;
        neg_d = neg_q;
        if (load) neg_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) neg_q <= 1'b0;
        else        neg_q <= neg_d;
    end
`else
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    always_comb begin
        sum     = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        shifted = {sum, acc_q[WIDTH-1:1]};
`ifdef MULT_SIGNED_EN
        result  = (negate && neg_q) ? PW'(~shifted + 1'b1) : shifted;
`else
        result  = shifted;
`endif
    end

    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        if (load) begin
            mcand_d = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
        end else if (step) begin
            acc_d   = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative radix-2 WIDTH x WIDTH multiplier with valid/ready on operands and product.
// Define MULT_SIGNED_EN to add the sgn port for two's complement operation.
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
`ifdef MULT_SIGNED_EN
    input  logic                   sgn,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     p,
    output logic                   busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam int PW = prod_width(WIDTH);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] p_q, p_d;
    logic          load, step, last;
    logic [PW-1:0] result;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is high only in IDLE and out_valid only in DONE, so no same-cycle pop/push.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == '0) begin
                    last    = 1'b1;
                    p_d     = result;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    mult_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
`ifdef MULT_SIGNED_EN
        .negate (last),
        .sgn    (sgn),
`endif
        .a      (a),
        .b      (b),
        .result (result)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC) || (state_q == DONE);
    assign p         = p_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier at WIDTH=8 and WIDTH=4; signed cases need MULT_SIGNED_EN.
module tb_seq_shift_add_multiplier;

    localparam int W  = 8;
    localparam int W4 = 4;

    logic            clk;
    logic            rst_n;
    logic            in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [W-1:0]    a8, b8;
    logic [2*W-1:0]  p8;
    logic            in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [W4-1:0]   a4, b4;
    logic [2*W4-1:0] p4;
`ifdef MULT_SIGNED_EN
    logic            sgn8, sgn4;
`endif

    int checks = 0;
    int errors = 0;

    seq_shift_add_multiplier #(.WIDTH(W)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
`ifdef MULT_SIGNED_EN
        .sgn       (sgn8),
`endif
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .p         (p8),
        .busy      (busy8)
    );

    seq_shift_add_multiplier #(.WIDTH(W4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
`ifdef MULT_SIGNED_EN
        .sgn       (sgn4),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .p         (p4),
        .busy      (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact product of the operands as integers, truncated to 2*W bits.
    function automatic logic [2*W-1:0] model8(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic s);
        longint xi, yi;
        xi = s ? longint'($signed(x)) : longint'(x);
        yi = s ? longint'($signed(y)) : longint'(y);
        return (2*W)'(xi * yi);
    endfunction

    task automatic run8(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                        input int hold, input string name);
        logic [2*W-1:0] exp;
        int n;
        exp = model8(ta, tb_, ts);
        @(negedge clk);
        a8 = ta;
        b8 = tb_;
`ifdef MULT_SIGNED_EN
        sgn8 = ts;
`endif
        in_valid8 = 1'b1;
        checks++;
        if (in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: in_ready=%b required 1", name, in_ready8);
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        a8 = W'($urandom);
        b8 = W'($urandom);
        n = 1;
        while (out_valid8 !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== W + 1) begin
            errors++;
            $display("FAIL %s latency: out_valid at cycle %0d required %0d", name, n, W + 1);
        end
        checks++;
        if (p8 !== exp) begin
            errors++;
            $display("FAIL %s product: p=%h required %h", name, p8, exp);
        end
        checks++;
        if (in_ready8 !== 1'b0 || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL %s done flags: in_ready=%b busy=%b required 0 1", name, in_ready8, busy8);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid8 = 1'b1;
            a8 = W'($urandom);
            b8 = W'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid8 !== 1'b1 || p8 !== exp || in_ready8 !== 1'b0) begin
                errors++;
                $display("FAIL %s hold: out_valid=%b p=%h in_ready=%b required 1 %h 0",
                         name, out_valid8, p8, in_ready8, exp);
            end
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0 || p8 !== exp) begin
            errors++;
            $display("FAIL %s pop: out_valid=%b in_ready=%b busy=%b p=%h required 0 1 0 %h",
                     name, out_valid8, in_ready8, busy8, p8, exp);
        end
    endtask

    task automatic run4(input logic [W4-1:0] ta, input logic [W4-1:0] tb_, input string name);
        logic [2*W4-1:0] exp;
        int n;
        exp = (2*W4)'(int'(ta) * int'(tb_));
        a4 = ta;
        b4 = tb_;
        in_valid4 = 1'b1;
        checks++;
        if (in_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: in_ready=%b required 1", name, in_ready4);
        end
        @(negedge clk);
        in_valid4 = 1'b0;
        n = 1;
        while (out_valid4 !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== W4 + 1 || p4 !== exp) begin
            errors++;
            $display("FAIL %s result: cycle=%0d p=%h required %0d %h", name, n, p4, W4 + 1, exp);
        end
        checks++;
        if (in_ready4 !== 1'b0) begin
            errors++;
            $display("FAIL %s done in_ready: got %b required 0", name, in_ready4);
        end
        @(negedge clk);
        checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL %s pop: out_valid=%b in_ready=%b required 0 1", name, out_valid4, in_ready4);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid8 = 1'b1;
        in_valid4 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || p8 !== '0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b p=%h busy=%b required 1 0 0000 0",
                     in_ready8, out_valid8, p8, busy8);
        end
        in_valid8 = 1'b0;
        in_valid4 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (in_ready8 !== 1'b1 || busy8 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL idle after reset: in_ready=%b busy=%b required 1 0", in_ready8, busy8);
        end
    endtask

    task automatic test_basic();
        run8(8'd13, 8'd11, 1'b0, 0, "mul_13x11");
        run8(8'hFF, 8'hFF, 1'b0, 5, "mul_ffxff_hold");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run8(W'($urandom), W'($urandom), 1'b0, $urandom_range(0, 3), "rand_unsigned");
    endtask

    task automatic test_back_to_back();
        out_ready4 = 1'b1;
        @(negedge clk);
        run4(4'h0, 4'hF, "b2b_0xf");
        run4(4'hF, 4'h0, "b2b_fx0");
        run4(4'hF, 4'hF, "b2b_fxf");
        out_ready4 = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        a8 = 8'd200;
        b8 = 8'd3;
        in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0 || p8 !== '0) begin
            errors++;
            $display("FAIL mid_calc_reset: in_ready=%b out_valid=%b busy=%b p=%h required 1 0 0 0000",
                     in_ready8, out_valid8, busy8, p8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run8(8'd7, 8'd6, 1'b0, 1, "after_reset_7x6");
    endtask

`ifdef MULT_SIGNED_EN
    task automatic test_signed();
        run8(8'hFF, 8'h01, 1'b1, 0, "signed_m1x1");
        run8(8'h80, 8'h80, 1'b1, 0, "signed_m128xm128");
        run8(8'hFB, 8'h07, 1'b1, 2, "signed_m5x7");
        for (int i = 0; i < 12; i++)
            run8(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 0, "rand_signed");
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        in_valid8 = 1'b0;
        out_ready8 = 1'b0;
        a8 = '0;
        b8 = '0;
        in_valid4 = 1'b0;
        out_ready4 = 1'b0;
        a4 = '0;
        b4 = '0;
`ifdef MULT_SIGNED_EN
        sgn8 = 1'b0;
        sgn4 = 1'b0;
`endif
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid_calc();
        test_random();
`ifdef MULT_SIGNED_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
